// File: rtl/spy_pkg.sv
// Shared definitions for the AXI spy trace path: channel encoding,
// output-register states and a small index helper for the arbiter.
package spy_pkg;

    // Number of spy channels (AR, AW, W, R). The encoding below depends on it.
    localparam int NUM_CH   = 4;
    localparam int CH_IDX_W = 2;

    // Source-channel tag carried with every trace entry.
    typedef enum logic [CH_IDX_W-1:0] {
        CH_AR = 2'd0,
        CH_AW = 2'd1,
        CH_W  = 2'd2,
        CH_R  = 2'd3
    } spy_ch_e;

    // Output register occupancy.
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    // (base + off) mod NUM_CH, used to walk the channels from the RR pointer.
    function automatic logic [CH_IDX_W-1:0] ch_wrap_add(
        input logic [CH_IDX_W-1:0] base,
        input int unsigned         off
    );
        int unsigned sum;
        sum = int'(base) + off;
        return CH_IDX_W'(sum % NUM_CH);
    endfunction

endpackage

// File: rtl/spy_trace_arbiter_if.sv
// Bundle of the spy-FIFO side and trace-sink side signals of the arbiter.
// master: the arbiter. slave: whatever drives the FIFOs and sinks the trace.
interface spy_trace_arbiter_if
    import spy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 16
);

    // Spy FIFO side (first-word-fall-through heads, channel i in slice i)
    logic [NUM_CH-1:0]            ch_empty;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_pop;

    // Trace sink side
    logic                         trace_valid;
    logic                         trace_ready;
    logic [DATA_WIDTH-1:0]        trace_data;
    logic [CH_IDX_W-1:0]          trace_ch;
    logic [SEQ_WIDTH-1:0]         trace_seq;
    logic                         busy;

    modport master (
        input  ch_empty,
        input  ch_data,
        output ch_pop,
        output trace_valid,
        input  trace_ready,
        output trace_data,
        output trace_ch,
        output trace_seq,
        output busy
    );

    modport slave (
        output ch_empty,
        output ch_data,
        input  ch_pop,
        input  trace_valid,
        output trace_ready,
        input  trace_data,
        input  trace_ch,
        input  trace_seq,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// NUM_CH-way round-robin arbiter. The search starts at the internal pointer
// and wraps; the pointer moves past the winner only when the grant is used.
module rr_arbiter
    import spy_pkg::*;
(
    input  logic                clk,
    input  logic                reset,        // async, active low
    input  logic [NUM_CH-1:0]   req,
    input  logic                advance,      // grant consumed this cycle
    output logic [NUM_CH-1:0]   grant,        // one-hot
    output logic [CH_IDX_W-1:0] grant_idx,
    output logic                grant_valid
);

    logic [CH_IDX_W-1:0] ptr_q;
    logic [CH_IDX_W-1:0] ptr_d;

    // Channel index and request seen at each search offset from the pointer.
    logic [CH_IDX_W-1:0] cand_idx [NUM_CH];
    logic [NUM_CH-1:0]   cand_req;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand_idx[gi] = ch_wrap_add(ptr_q, gi);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Pick the requester closest to the pointer. Scanning from the far end
    // lets the nearest match overwrite earlier ones without a break.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // One-hot form of the winning index.
    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to the channel after the winner, only on a used grant.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = ch_wrap_add(grant_idx, 1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spy_trace_arbiter.sv
// Drains the four AXI spy FIFOs into a single valid/ready trace stream.
// Each entry carries its source channel and a global sequence number so the
// capture can be re-ordered offline. One entry per cycle when the sink keeps
// ready high; the pop strobe for the next entry is issued in the same cycle
// as the handshake of the current one.
module spy_trace_arbiter
    import spy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 16
)
(
    input  logic              clk,
    input  logic              reset,      // async, active low
    input  logic              enable,     // permits new pops
    input  logic [NUM_CH-1:0] ch_mask,    // per-channel service enable
    spy_trace_arbiter_if.master bus
);

    // Per-channel view of the FIFO head words.
    logic [DATA_WIDTH-1:0] ch_word [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_word[gi] = bus.ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Output register, sequence counter and their next values.
    out_state_e            state_q,      state_d;
    logic [DATA_WIDTH-1:0] trace_data_q, trace_data_d;
    spy_ch_e               trace_ch_q,   trace_ch_d;
    logic [SEQ_WIDTH-1:0]  trace_seq_q,  trace_seq_d;
    logic [SEQ_WIDTH-1:0]  seq_cnt_q,    seq_cnt_d;

    logic [NUM_CH-1:0]     elig;
    logic [NUM_CH-1:0]     gnt;
    logic [CH_IDX_W-1:0]   gnt_idx;
    logic                  gnt_valid;
    logic                  handshake;
    logic                  load;

    // A channel is a candidate when its FIFO has data and it is unmasked.
    assign elig = ~bus.ch_empty & ch_mask;

    rr_arbiter u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req         (elig),
        .advance     (load),
        .grant       (gnt),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    // Load when the register is free or being emptied by the sink this cycle.
    // Under backpressure no load happens, so the payload and ch_pop stay put.
    always_comb begin
        state_d      = state_q;
        trace_data_d = trace_data_q;
        trace_ch_d   = trace_ch_q;
        trace_seq_d  = trace_seq_q;
        seq_cnt_d    = seq_cnt_q;

        handshake = (state_q == OUT_HOLD) && bus.trace_ready;
        load      = enable && gnt_valid && ((state_q == OUT_EMPTY) || handshake);

        if (load) begin
            state_d      = OUT_HOLD;
            trace_data_d = ch_word[gnt_idx];
            trace_ch_d   = spy_ch_e'(gnt_idx);
            trace_seq_d  = seq_cnt_q;
            seq_cnt_d    = seq_cnt_q + SEQ_WIDTH'(1);
        end else if (handshake) begin
            state_d = OUT_EMPTY;
        end
    end

    // Output register and sequence counter; reset drops valid immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= OUT_EMPTY;
            trace_data_q <= '0;
            trace_ch_q   <= CH_AR;
            trace_seq_q  <= '0;
            seq_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            trace_data_q <= trace_data_d;
            trace_ch_q   <= trace_ch_d;
            trace_seq_q  <= trace_seq_d;
            seq_cnt_q    <= seq_cnt_d;
        end
    end

    // The pop strobe is combinational from the grant so the FIFO head is
    // consumed at the same edge that captures it; it is gated off in reset.
    assign bus.ch_pop      = {NUM_CH{load & reset}} & gnt;
    assign bus.trace_valid = (state_q == OUT_HOLD);
    assign bus.busy        = (state_q == OUT_HOLD);
    assign bus.trace_data  = trace_data_q;
    assign bus.trace_ch    = trace_ch_q;
    assign bus.trace_seq   = trace_seq_q;

endmodule

// File: doc/spy_trace_arbiter.md
Name: spy_trace_arbiter

Overview:
- Drains the four per-channel AXI spy FIFOs (AR, AW, W, R) into one trace output stream.
- Arbitration is round-robin, and the output handshake is valid/ready.
- Each emitted entry is tagged with its source channel and a global sequence number, so captured transactions can be reordered offline.
- Sits between the spy FIFOs and the trace sink (debug buffer or off-chip link).
- Owns the FIFO pop strobes.

Parameters:
- DATA_WIDTH, 32, width of one spy FIFO entry and of trace_data.
- NUM_CH, 4, number of spy channels. Fixed at 4; the channel encoding lives in the package.
- SEQ_WIDTH, 16, width of the sequence counter and of trace_seq.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allows new pops when high.
- ch_mask  in  NUM_CH  per-channel service enable. Bit i = channel i.
- ch_empty  in  NUM_CH  spy FIFO empty flags.
- ch_data  in  NUM_CH*DATA_WIDTH  FIFO head data, first-word-fall-through. Slice i = channel i.
- ch_pop  out  NUM_CH  one-hot pop strobe. Consumes the head at the next rising edge.
- trace_valid  out  1  trace entry valid.
- trace_ready  in  1  sink accepts the entry.
- trace_data  out  DATA_WIDTH  captured payload.
- trace_ch  out  2  source channel: 0=AR, 1=AW, 2=W, 3=R.
- trace_seq  out  SEQ_WIDTH  sequence number of the entry.
- busy  out  1  equals trace_valid.

Behaviour:
- Reset values:
  - reset low asynchronously clears trace_valid, trace_data, trace_ch, trace_seq, the seq counter and the RR pointer to 0.
  - ch_pop is forced to 0 while reset is low.
- Eligibility: elig = ~ch_empty & ch_mask.
- Output register states:
  - EMPTY (trace_valid=0).
  - HOLD (trace_valid=1).
- Load condition: load = enable & |elig & (EMPTY | (trace_valid & trace_ready)).
- On load:
  - ch_pop[g] = 1 combinationally in that cycle, where g is the RR grant. All other bits are 0.
  - At the next edge: trace_data <= ch_data[g], trace_ch <= g, trace_seq <= seq_cnt, seq_cnt <= seq_cnt+1, state <= HOLD.
- Handshake (trace_valid & trace_ready) without a load: state <= EMPTY.
- Handshake with a load: state stays HOLD with the new entry. This is back-to-back operation, one entry per cycle.
- Latency: elig seen in cycle N -> pop in cycle N -> trace_valid in cycle N+1.
- Backpressure:
  - While trace_valid & ~trace_ready, trace_data, trace_ch and trace_seq are held stable.
  - ch_pop stays 0 during backpressure.
- Round-robin:
  - Search starts at ptr and wraps at NUM_CH-1 -> 0.
  - After grant g, ptr <= (g+1) mod NUM_CH.
  - ptr is unchanged when there is no grant.
  - A continuously eligible channel is served within NUM_CH grants.
- seq_cnt wraps from all-ones to 0 silently. It increments only on load.
- enable deassertion: no new pops. An entry already in HOLD still completes its handshake.
- A ch_mask change affects only future grants, never the held entry.
- A channel whose empty flag rises in the same cycle as its pop is not re-granted the following cycle unless ch_empty is low again.
- Async reset while in HOLD: trace_valid drops immediately, with no clock edge required. The held entry is lost by design.

Decomposition:
- Package spy_pkg holds:
  - typedef enum logic[1:0] spy_ch_e {CH_AR, CH_AW, CH_W, CH_R}.
  - localparam NUM_CH = 4.
- Sub-module rr_arbiter (NUM_CH-way):
  - Inputs: req, advance.
  - Outputs: one-hot grant, grant index.
  - Holds the pointer register internally.
- Top level holds the output register, seq counter and load/handshake logic.

Test Plan:
1. Reset: hold reset low with ch_empty=4'b0000 and toggle clk -> ch_pop=0, trace_valid=0, trace_seq=0. Assert reset mid-HOLD without a clock edge -> trace_valid falls immediately.
2. Single entry: only the W FIFO non-empty, head 0xDEADBEEF, trace_ready=1 -> ch_pop=4'b0100 for one cycle. Next cycle: trace_valid=1, trace_data=0xDEADBEEF, trace_ch=2, trace_seq=0.
3. Fairness: all four FIFOs hold 3 entries, ready=1 -> pops in channel order 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles, trace_seq 0..11, no idle cycles.
4. Backpressure: trace_ready=0 for 5 cycles with FIFOs non-empty -> payload stable and ch_pop=0 for all 5 cycles. Raise ready -> a new pop occurs in the same cycle as the handshake.
5. Mask and enable: ch_mask=4'b1010 -> only ch_pop values 4'b0010 and 4'b1000 appear, alternating. Drop enable while in HOLD -> the held entry is delivered, then no further ch_pop.
6. Wrap: with SEQ_WIDTH=4, stream 17 entries -> trace_seq runs 0..15 then 0.
